pipe_hazard_ctrl: RTL and testbench

//  Central hazard/sequencing controller for the 5-stage pipeline. Decides, each cycle, whether
//  IF/ID, ID/EX, EX/MEM and MEM/WB advance, stall, flush or take a bubble. Drives ID/EX bubble,
//  EX-stage forwarding selects and a memory-wait freeze FSM with timeout. Keeps saturating

---
 rtl/pipe_hazard_ctrl.sv | 178 +++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for a 5-stage pipeline: stage enables, flush/bubble,
// EX forwarding selects, memory-wait freeze with timeout, and saturating perf counters.
module pipe_hazard_ctrl #(
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [4:0]       ID_Rs,
    input  logic [4:0]       ID_Rt,
    input  logic             ID_UsesRt,
    input  logic [4:0]       EX_Rs,
    input  logic [4:0]       EX_Rt,
    input  logic             EX_MemtoReg,
    input  logic             EX_Take,
    input  logic             MEM_RegWr,
    input  logic [4:0]       MEM_Rw,
    input  logic             WB_RegWr,
    input  logic [4:0]       WB_Rw,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             PC_We,
    output logic             IFID_We,
    output logic             IFID_flush,
    output logic             IDEX_We,
    output logic             IDEX_bubble,
    output logic             EXMEM_We,
    output logic             MEMWB_We,
    output logic [1:0]       ForwardA,
    output logic [1:0]       ForwardB,
    output logic             err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int WC_W = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_WAIT = 2'd1,
        S_ERR  = 2'd2
    } state_t;

    state_t             r_state;
    logic [WC_W-1:0]    r_wait_cnt;
    logic               r_err;
    logic [CNT_W-1:0]   r_stall_cnt;
    logic [CNT_W-1:0]   r_flush_cnt;

    logic w_freeze;
    logic w_lu;
    logic w_advance;
    logic w_take;
    logic w_stall;

    // Select MEM result over WB result; $0 is hardwired and never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input logic       mem_wr,
        input logic [4:0] mem_rw,
        input logic       wb_wr,
        input logic [4:0] wb_rw
    );
        logic [1:0] sel;
        if (mem_wr && (mem_rw != 5'd0) && (mem_rw == src)) begin
            sel = 2'b10;
        end else if (wb_wr && (wb_rw != 5'd0) && (wb_rw == src)) begin
            sel = 2'b01;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    // Hazard detection and the per-cycle advance/flush/stall decision.
    always_comb begin
        w_freeze  = mem_req & ~mem_ready;
        w_lu      = EX_MemtoReg & (EX_Rt != 5'd0) &
                    ((EX_Rt == ID_Rs) | (ID_UsesRt & (EX_Rt == ID_Rt)));
        w_advance = 1'b0;
        if (Rst) begin
            w_advance = 1'b0;
        end else begin
            case (r_state)
                S_RUN:   w_advance = ~w_freeze;
                S_WAIT:  w_advance = mem_ready;
                S_ERR:   w_advance = 1'b0;
                default: w_advance = 1'b0;
            endcase
        end
        w_take  = w_advance & EX_Take;
        w_stall = w_advance & ~EX_Take & w_lu;
    end

    // Stage enables and forwarding selects; everything held quiet while in reset.
    always_comb begin
        PC_We       = w_advance & ~w_stall;
        IFID_We     = w_advance & ~w_stall;
        IFID_flush  = w_take;
        IDEX_We     = w_advance;
        IDEX_bubble = w_take | w_stall;
        EXMEM_We    = w_advance;
        MEMWB_We    = w_advance;
        ForwardA    = 2'b00;
        ForwardB    = 2'b00;
        if (Rst) begin
            ForwardA = 2'b00;
            ForwardB = 2'b00;
        end else begin
            ForwardA = fwd_sel(EX_Rs, MEM_RegWr, MEM_Rw, WB_RegWr, WB_Rw);
            ForwardB = fwd_sel(EX_Rt, MEM_RegWr, MEM_Rw, WB_RegWr, WB_Rw);
        end
    end

    // Memory-wait FSM; the first frozen cycle is spent in RUN, hence wait_cnt starts at 1.
    always_ff @(negedge Clk) begin
        if (Rst) begin
            r_state    <= S_RUN;
            r_wait_cnt <= '0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (w_freeze) begin
                        r_state    <= S_WAIT;
                        r_wait_cnt <= WC_W'(1);
                    end else begin
                        r_state    <= S_RUN;
                        r_wait_cnt <= '0;
                    end
                end
                S_WAIT: begin
                    if (mem_ready) begin
                        r_state    <= S_RUN;
                        r_wait_cnt <= '0;
                    end else if (r_wait_cnt == WC_W'(MAX_WAIT - 1)) begin
                        r_state <= S_ERR;
                        r_err   <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + WC_W'(1);
                    end
                end
                S_ERR: begin
                    r_state <= S_ERR;
                    r_err   <= 1'b1;
                end
                default: begin
                    r_state    <= S_RUN;
                    r_wait_cnt <= '0;
                end
            endcase
        end
    end

    // Saturating performance counters, stepped only when the action is actually driven.
    always_ff @(negedge Clk) begin
        if (Rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end else begin
                r_stall_cnt <= r_stall_cnt;
            end
            if (w_take && (r_flush_cnt != {CNT_W{1'b1}})) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end else begin
                r_flush_cnt <= r_flush_cnt;
            end
        end
    end

    assign err       = r_err;
    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios with literal expectations, then random
// stimulus checked every cycle against a behavioural model. A CNT_W=2 copy exercises saturation.
module tb_pipe_hazard_ctrl;

    localparam int MAXW = 16;

    logic       Clk = 1'b0;
    logic       Rst;
    logic [4:0] ID_Rs, ID_Rt, EX_Rs, EX_Rt, MEM_Rw, WB_Rw;
    logic       ID_UsesRt, EX_MemtoReg, EX_Take, MEM_RegWr, WB_RegWr, mem_req, mem_ready;

    logic        PC_We, IFID_We, IFID_flush, IDEX_We, IDEX_bubble, EXMEM_We, MEMWB_We, err;
    logic [1:0]  ForwardA, ForwardB;
    logic [15:0] stall_cnt, flush_cnt;

    logic        s_PC_We, s_IFID_We, s_IFID_flush, s_IDEX_We, s_IDEX_bubble, s_EXMEM_We, s_MEMWB_We, s_err;
    logic [1:0]  s_ForwardA, s_ForwardB;
    logic [1:0]  s_stall_cnt, s_flush_cnt;

    always #5 Clk = ~Clk;

    pipe_hazard_ctrl #(.MAX_WAIT(MAXW), .CNT_W(16)) u_dut (
        .Clk(Clk), .Rst(Rst), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt),
        .EX_Rs(EX_Rs), .EX_Rt(EX_Rt), .EX_MemtoReg(EX_MemtoReg), .EX_Take(EX_Take),
        .MEM_RegWr(MEM_RegWr), .MEM_Rw(MEM_Rw), .WB_RegWr(WB_RegWr), .WB_Rw(WB_Rw),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .PC_We(PC_We), .IFID_We(IFID_We), .IFID_flush(IFID_flush), .IDEX_We(IDEX_We),
        .IDEX_bubble(IDEX_bubble), .EXMEM_We(EXMEM_We), .MEMWB_We(MEMWB_We),
        .ForwardA(ForwardA), .ForwardB(ForwardB), .err(err),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipe_hazard_ctrl #(.MAX_WAIT(MAXW), .CNT_W(2)) u_sat (
        .Clk(Clk), .Rst(Rst), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt),
        .EX_Rs(EX_Rs), .EX_Rt(EX_Rt), .EX_MemtoReg(EX_MemtoReg), .EX_Take(EX_Take),
        .MEM_RegWr(MEM_RegWr), .MEM_Rw(MEM_Rw), .WB_RegWr(WB_RegWr), .WB_Rw(WB_Rw),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .PC_We(s_PC_We), .IFID_We(s_IFID_We), .IFID_flush(s_IFID_flush), .IDEX_We(s_IDEX_We),
        .IDEX_bubble(s_IDEX_bubble), .EXMEM_We(s_EXMEM_We), .MEMWB_We(s_MEMWB_We),
        .ForwardA(s_ForwardA), .ForwardB(s_ForwardB), .err(s_err),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: count of consecutive frozen cycles, dead flag, raw event counts.
    int frozen_run = 0;
    bit dead       = 1'b0;
    int n_stall    = 0;
    int n_flush    = 0;
    bit m_take, m_stall, m_frozen;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at time %0t", name, act, exp, $time);
        end
    endtask

    function automatic int fwd(input logic [4:0] src);
        if (MEM_RegWr && MEM_Rw != 0 && MEM_Rw == src) return 2;
        if (WB_RegWr && WB_Rw != 0 && WB_Rw == src) return 1;
        return 0;
    endfunction

    function automatic int sat(input int n, input int w);
        int top;
        top = (1 << w) - 1;
        return (n > top) ? top : n;
    endfunction

    // Compare every DUT output against the model, at the posedge (state moves on negedge).
    task automatic eval();
        bit lu, go;
        int e_adv, e_hold, fa, fb;
        @(posedge Clk);
        lu = EX_MemtoReg && EX_Rt != 0 && (EX_Rt == ID_Rs || (ID_UsesRt && EX_Rt == ID_Rt));
        m_frozen = (frozen_run > 0) ? !mem_ready : (mem_req && !mem_ready);
        go      = !Rst && !dead && !m_frozen;
        m_take  = go && EX_Take;
        m_stall = go && !EX_Take && lu;
        e_adv   = go ? 1 : 0;
        e_hold  = (go && !m_stall) ? 1 : 0;
        fa = Rst ? 0 : fwd(EX_Rs);
        fb = Rst ? 0 : fwd(EX_Rt);
        chk("PC_We",       PC_We,       e_hold);
        chk("IFID_We",     IFID_We,     e_hold);
        chk("IFID_flush",  IFID_flush,  m_take ? 1 : 0);
        chk("IDEX_We",     IDEX_We,     e_adv);
        chk("IDEX_bubble", IDEX_bubble, (m_take || m_stall) ? 1 : 0);
        chk("EXMEM_We",    EXMEM_We,    e_adv);
        chk("MEMWB_We",    MEMWB_We,    e_adv);
        chk("ForwardA",    ForwardA,    fa);
        chk("ForwardB",    ForwardB,    fb);
        chk("err",         err,         dead ? 1 : 0);
        chk("stall_cnt",   stall_cnt,   sat(n_stall, 16));
        chk("flush_cnt",   flush_cnt,   sat(n_flush, 16));
        chk("sat_PC_We",   s_PC_We,     e_hold);
        chk("sat_err",     s_err,       dead ? 1 : 0);
        chk("sat_stall",   s_stall_cnt, sat(n_stall, 2));
        chk("sat_flush",   s_flush_cnt, sat(n_flush, 2));
    endtask

    // Advance the model across the negedge and re-drive inputs just after it.
    task automatic adv();
        if (Rst) begin
            frozen_run = 0; dead = 1'b0; n_stall = 0; n_flush = 0;
        end else if (!dead) begin
            if (m_frozen) begin
                frozen_run++;
                if (frozen_run >= MAXW) dead = 1'b1;
            end else begin
                frozen_run = 0;
                if (m_take) n_flush++;
                if (m_stall) n_stall++;
            end
        end
        @(negedge Clk);
        #1;
    endtask

    task automatic neutral();
        Rst = 1'b0; ID_Rs = 5'd0; ID_Rt = 5'd0; ID_UsesRt = 1'b0; EX_Rs = 5'd0; EX_Rt = 5'd0;
        EX_MemtoReg = 1'b0; EX_Take = 1'b0; MEM_RegWr = 1'b0; MEM_Rw = 5'd0;
        WB_RegWr = 1'b0; WB_Rw = 5'd0; mem_req = 1'b0; mem_ready = 1'b1;
    endtask

    task automatic do_reset();
        neutral(); Rst = 1'b1;
        eval(); chk("rst_PC_We", PC_We, 0); chk("rst_MEMWB_We", MEMWB_We, 0);
        adv(); Rst = 1'b0;
    endtask

    int hold_low;

    initial begin
        neutral();
        Rst = 1'b1;
        @(negedge Clk); #1;
        do_reset();
        eval(); chk("lit_reset_stall", stall_cnt, 0); chk("lit_reset_err", err, 0);
        chk("lit_reset_PC_We", PC_We, 1); adv();

        // Load-use on rs: one stall cycle
        EX_MemtoReg = 1'b1; EX_Rt = 5'd2; ID_Rs = 5'd2;
        eval(); chk("lit_lu_PC_We", PC_We, 0); chk("lit_lu_IFID_We", IFID_We, 0);
        chk("lit_lu_bubble", IDEX_bubble, 1); chk("lit_lu_EXMEM_We", EXMEM_We, 1); adv();
        neutral();
        eval(); chk("lit_lu_stall_cnt", stall_cnt, 1); chk("lit_lu_after_PC", PC_We, 1); adv();

        // Load-use and taken branch together: the flush wins
        do_reset();
        EX_MemtoReg = 1'b1; EX_Rt = 5'd3; ID_Rt = 5'd3; ID_UsesRt = 1'b1; EX_Take = 1'b1;
        eval(); chk("lit_take_flush", IFID_flush, 1); chk("lit_take_bubble", IDEX_bubble, 1);
        chk("lit_take_PC_We", PC_We, 1); adv();
        neutral();
        eval(); chk("lit_take_flush_cnt", flush_cnt, 1); chk("lit_take_stall_cnt", stall_cnt, 0); adv();

        // Forwarding priority and $0
        MEM_RegWr = 1'b1; WB_RegWr = 1'b1; MEM_Rw = 5'd5; WB_Rw = 5'd5; EX_Rs = 5'd5;
        eval(); chk("lit_fwdA_mem", ForwardA, 2); adv();
        MEM_RegWr = 1'b0;
        eval(); chk("lit_fwdA_wb", ForwardA, 1); adv();
        EX_Rs = 5'd0; MEM_Rw = 5'd0; WB_Rw = 5'd0; MEM_RegWr = 1'b1;
        eval(); chk("lit_fwdA_zero", ForwardA, 0); adv();
        neutral();

        // Three frozen cycles, release on the fourth
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            eval(); chk("lit_wait_PC_We", PC_We, 0); chk("lit_wait_MEMWB_We", MEMWB_We, 0); adv();
        end
        mem_ready = 1'b1;
        eval(); chk("lit_release_PC_We", PC_We, 1); adv();
        mem_req = 1'b0;
        eval(); chk("lit_run_again", MEMWB_We, 1); adv();

        // Timeout: 16 frozen cycles then sticky error
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < MAXW; i++) begin
            eval(); adv();
        end
        mem_ready = 1'b1;
        eval(); chk("lit_err_set", err, 1); chk("lit_err_PC_We", PC_We, 0); adv();
        neutral();
        eval(); chk("lit_err_sticky", err, 1); adv();
        do_reset();
        eval(); chk("lit_err_cleared", err, 0); adv();

        // Saturation of the 2-bit counter after 5 stalls
        EX_MemtoReg = 1'b1; EX_Rt = 5'd7; ID_Rs = 5'd7;
        for (int i = 0; i < 5; i++) begin
            eval(); adv();
        end
        neutral();
        eval(); chk("lit_sat_stall", s_stall_cnt, 3); chk("lit_wide_stall", stall_cnt, 5); adv();

        // Randomized phase
        hold_low = 0;
        for (int c = 0; c < 4000; c++) begin
            Rst         = ($urandom_range(0, 149) == 0);
            ID_Rs       = 5'($urandom_range(0, 3));
            ID_Rt       = 5'($urandom_range(0, 3));
            ID_UsesRt   = 1'($urandom_range(0, 1));
            EX_Rs       = 5'($urandom_range(0, 3));
            EX_Rt       = 5'($urandom_range(0, 3));
            EX_MemtoReg = 1'($urandom_range(0, 1));
            EX_Take     = ($urandom_range(0, 5) == 0);
            MEM_RegWr   = 1'($urandom_range(0, 1));
            MEM_Rw      = 5'($urandom_range(0, 3));
            WB_RegWr    = 1'($urandom_range(0, 1));
            WB_Rw       = 5'($urandom_range(0, 3));
            mem_req     = ($urandom_range(0, 3) == 0);
            if (hold_low == 0 && $urandom_range(0, 299) == 0) hold_low = $urandom_range(10, 20);
            if (hold_low > 0) begin
                mem_ready = 1'b0; hold_low--;
            end else begin
                mem_ready = ($urandom_range(0, 3) != 0);
            end
            eval();
            adv();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
